// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
//
// Direct-mapped, write-through, no-write-allocate data cache controller that
// sits between the processor's memory-access path and a multi-cycle backing
// memory. One 32-bit word per line. Load hits complete combinationally in the
// request cycle; load misses and all stores hold `stall` high until the
// backing memory pulses `mem_ready`.
//
// Optional feature (macro DCACHE_STATS_EN): when defined, adds the outputs
// hit_count / miss_count, which count completed load hits and read-miss
// entries. Without the macro those ports and counters do not exist.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   en         in   access request valid this cycle
//   wr         in   1 = store, 0 = load (qualified by en)
//   addr       in   byte address (bits [1:0] ignored)
//   data_in    in   store data
//   data_out   out  load data, valid when en & ~wr & ~stall
//   stall      out  processor must hold the request and freeze
//   mem_rd     out  backing-memory read strobe
//   mem_wr     out  backing-memory write strobe
//   mem_addr   out  backing-memory word address (low two bits zero)
//   mem_wdata  out  backing-memory write data
//   mem_rdata  in   backing-memory read data, valid with mem_ready
//   mem_ready  in   one-cycle pulse: backing-memory operation done
//   hit_count  out  (DCACHE_STATS_EN only) completed load hits
//   miss_count out  (DCACHE_STATS_EN only) read-miss entries
// -----------------------------------------------------------------------------
module dcache_ctrl #(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              stall,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_t;

    state_t state_r;
    state_t next_state_s;

    // Line storage: valid bits are reset, tags and data are not.
    logic [LINES-1:0] valid_r;
    logic [TAG_W-1:0] tag_r  [LINES];
    logic [31:0]      line_r [LINES];

    // Request copies taken when leaving IDLE; memory is driven from these.
    logic [ADDR_W-1:0] lat_addr_r;
    logic [31:0]       lat_data_r;

    logic [INDEX_BITS-1:0] req_index_s;
    logic [TAG_W-1:0]      req_tag_s;
    logic [INDEX_BITS-1:0] lat_index_s;
    logic [TAG_W-1:0]      lat_tag_s;
    logic                  hit_s;
    logic                  lat_hit_s;
    logic                  latch_s;
    logic                  fill_s;
    logic                  upd_s;
    logic                  unused_addr_bits_s;

    assign req_index_s = addr[INDEX_BITS+1:2];
    assign req_tag_s   = addr[ADDR_W-1:INDEX_BITS+2];
    assign lat_index_s = lat_addr_r[INDEX_BITS+1:2];
    assign lat_tag_s   = lat_addr_r[ADDR_W-1:INDEX_BITS+2];

    // Byte-offset bits play no part in a word-granular cache.
    assign unused_addr_bits_s = ^addr[1:0];

    assign hit_s     = en & valid_r[req_index_s] & (tag_r[req_index_s] == req_tag_s);
    // Store-hit check is made against the latched address when the write lands.
    assign lat_hit_s = valid_r[lat_index_s] & (tag_r[lat_index_s] == lat_tag_s);

    // Strobes decode straight from the state register, so they fall the cycle after mem_ready.
    assign mem_rd    = (state_r == RD_MISS);
    assign mem_wr    = (state_r == WR_THRU);
    assign mem_addr  = lat_addr_r;
    assign mem_wdata = lat_data_r;

    // Next-state, stall and load-data decode.
    always_comb begin
        next_state_s = state_r;
        stall        = 1'b0;
        data_out     = 32'd0;
        latch_s      = 1'b0;
        fill_s       = 1'b0;
        upd_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (en) begin
                    if (wr) begin
                        stall        = 1'b1;
                        latch_s      = 1'b1;
                        next_state_s = WR_THRU;
                    end else if (hit_s) begin
                        data_out     = line_r[req_index_s];
                    end else begin
                        stall        = 1'b1;
                        latch_s      = 1'b1;
                        next_state_s = RD_MISS;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            RD_MISS: begin
                if (mem_ready) begin
                    // Forward the fill data in the same cycle it is written.
                    fill_s       = 1'b1;
                    data_out     = mem_rdata;
                    next_state_s = IDLE;
                end else begin
                    stall        = 1'b1;
                end
            end
            WR_THRU: begin
                if (mem_ready) begin
                    // No allocate: only a line already holding this address is refreshed.
                    upd_s        = lat_hit_s;
                    next_state_s = IDLE;
                end else begin
                    stall        = 1'b1;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, request latch and valid-bit register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            lat_addr_r <= {ADDR_W{1'b0}};
            lat_data_r <= 32'd0;
            valid_r    <= {LINES{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (latch_s) begin
                lat_addr_r <= {addr[ADDR_W-1:2], 2'b00};
                lat_data_r <= data_in;
            end
            if (fill_s) begin
                valid_r[lat_index_s] <= 1'b1;
            end
        end
    end

    // Tag and data arrays: written on a read fill or a store hit.
    always_ff @(posedge clk) begin
        if (fill_s) begin
            tag_r[lat_index_s]  <= lat_tag_s;
            line_r[lat_index_s] <= mem_rdata;
        end else if (upd_s) begin
            line_r[lat_index_s] <= lat_data_r;
        end
    end

`ifdef DCACHE_STATS_EN
    logic load_hit_s;
    logic miss_entry_s;

    assign load_hit_s   = (state_r == IDLE) & hit_s & ~wr;
    assign miss_entry_s = (state_r == IDLE) & (next_state_s == RD_MISS);

    // Hit / miss statistics counters (wrap naturally at 2^32).
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (load_hit_s) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_entry_s) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
